main_ctrl_decoder: RTL and testbench
====================================

Name: main_ctrl_decoder

Overview:
- Main control decoder for the multi-cycle 32-bit MIPS-like CPU.
- Maps the 6-bit instruction opcode (IR[31:26]) to a 14-bit control word.
- The datapath FSM consumes the control word in its decode, execute, memory and writeback stages.
- Output is registered: one-cycle latency, which fits the CPU's instruction-latch → decode stage gap.

Parameters:
- SIG_W, 14, control word width (fixed; not meant to be overridden).

Ports:
- clk, input, 1, clock; rising-edge active.
- rst, input, 1, reset, asynchronous, active-high.
- op, input, 6, instruction opcode.
- signal, output, 14, registered control word.
- illegal_op, output, 1, registered; 1 when op is not in the decode table.

Behaviour:
- Control word bit map:
  - bit 13 Membyte: byte memory access.
  - bit 12 ALUOP: R-type, ALU function taken from func field.
  - bit 11 SA: ALU A source; 1 = RA, 0 = PC.
  - bits 10-9 SB: ALU B source; 0 = RB, 1 = const 4, 2 = sign-ext imm, 3 = imm<<2.
  - bits 8-7 RegDst: 0 = RT, 1 = RD, 2 = reg 31, 3 unused.
  - bit 6 Mem2Reg; bit 5 RegW; bit 4 MemR; bit 3 MemW.
  - bit 2 PC_S: 1 = ALU result, 0 = jump target.
  - bit 1 PCWC: conditional PC write; bit 0 PCW: unconditional PC write.
- Decode table (op hex → signal hex):
  - 00 R-type → 18A0.
  - 02 J → 0001.
  - 03 JAL → 0321 (PC+4 written to reg 31).
  - 04 BEQ, 05 BNE → 0602.
  - 08 ADDI, 09 ADDIU, 0A SLTI, 0B SLTIU, 0C ANDI, 0D ORI, 0E XORI, 0F LUI → 0C20.
  - 23 LW → 0C70.
  - 20 LB, 24 LBU → 2C70.
  - 2B SW → 0C08.
  - 28 SB → 2C08.
  - 10 COP0 → 0000 (datapath handles COP0 directly); illegal_op = 0.
  - Any other op → 0000 with illegal_op = 1.
- Timing: signal and illegal_op update on every rising clk edge from the current op. Latency is exactly 1 cycle; no enable, no handshake.
- Reset:
  - rst high asynchronously forces signal = 0000 and illegal_op = 0 immediately.
  - Outputs hold those values while rst is high.
  - First decode happens at the first rising edge after rst falls.
- A cleared word (0000) must never write registers, memory or PC. Reset mid-instruction therefore leaves the datapath inert.
- op changing every cycle: each cycle's output reflects the op sampled at the previous edge. No glitch filtering.
- Exclusivity: PCW and PCWC are never both set; MemR and MemW are never both set; Mem2Reg implies MemR and RegW.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, ...);
  - control bit index constants (SIG_MEMBYTE = 13 … SIG_PCW = 0);
  - SB and RegDst encodings;
  - the 14-bit control word typedef.
- The datapath imports the same package.
- One natural sub-module, main_ctrl_comb: a purely combinational op → {signal, illegal} table. The top block registers its output.

Test Plan:
- Reset: assert rst mid-cycle with op = 23 → signal = 0000 and illegal_op = 0 immediately, without waiting for a clock edge. Release rst, clock once → signal = 0C70.
- Sweep: drive all 64 op values on consecutive cycles → each cycle's output matches the table for the previous cycle's op.
- Illegal ops: op = 3F or 01 → signal = 0000, illegal_op = 1. op = 10 → signal = 0000, illegal_op = 0.
- Byte vs word: op = 24 vs 23 differ only in bit 13 (2C70 vs 0C70); op = 28 vs 2B likewise (2C08 vs 0C08).
- Control flow: op = 02 → 0001; op = 03 → 0321; op = 04 and 05 → 0602. Check PCW and PCWC are never both set across all ops.
- Latency: change op from 00 to 2B between edges → signal stays 18A0 until the next rising edge, then becomes 0C08.

Source files
------------

// File: rtl/main_ctrl_decoder_pkg.sv
// Shared CPU control definitions: opcodes, control-word bit map and encodings.
// The datapath imports this package too, so field positions live in one place.
package cpu_ctrl_pkg;

    localparam int unsigned SIG_W = 14;

    typedef logic [SIG_W-1:0] ctrl_word_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int unsigned SIG_MEMBYTE   = 13;
    localparam int unsigned SIG_ALUOP     = 12;
    localparam int unsigned SIG_SA        = 11;
    localparam int unsigned SIG_SB_HI     = 10;
    localparam int unsigned SIG_SB_LO     = 9;
    localparam int unsigned SIG_REGDST_HI = 8;
    localparam int unsigned SIG_REGDST_LO = 7;
    localparam int unsigned SIG_MEM2REG   = 6;
    localparam int unsigned SIG_REGW      = 5;
    localparam int unsigned SIG_MEMR      = 4;
    localparam int unsigned SIG_MEMW      = 3;
    localparam int unsigned SIG_PCS       = 2;
    localparam int unsigned SIG_PCWC      = 1;
    localparam int unsigned SIG_PCW       = 0;

    typedef enum logic [1:0] {
        SB_RB   = 2'd0,
        SB_FOUR = 2'd1,
        SB_SEXT = 2'd2,
        SB_SHL2 = 2'd3
    } sb_sel_e;

    typedef enum logic [1:0] {
        RD_RT  = 2'd0,
        RD_RD  = 2'd1,
        RD_R31 = 2'd2
    } regdst_e;

    function automatic ctrl_word_t make_cw(
        input logic    membyte,
        input logic    aluop,
        input logic    sa,
        input sb_sel_e sb,
        input regdst_e rd,
        input logic    mem2reg,
        input logic    regw,
        input logic    memr,
        input logic    memw,
        input logic    pcs,
        input logic    pcwc,
        input logic    pcw
    );
        ctrl_word_t w;
        w                            = '0;
        w[SIG_MEMBYTE]               = membyte;
        w[SIG_ALUOP]                 = aluop;
        w[SIG_SA]                    = sa;
        w[SIG_SB_HI:SIG_SB_LO]       = sb;
        w[SIG_REGDST_HI:SIG_REGDST_LO] = rd;
        w[SIG_MEM2REG]               = mem2reg;
        w[SIG_REGW]                  = regw;
        w[SIG_MEMR]                  = memr;
        w[SIG_MEMW]                  = memw;
        w[SIG_PCS]                   = pcs;
        w[SIG_PCWC]                  = pcwc;
        w[SIG_PCW]                   = pcw;
        return w;
    endfunction

    //                                  mb    alu   sa    sb       rd      m2r   rw    mr    mw    pcs   pcwc  pcw
    localparam ctrl_word_t CW_RTYPE = make_cw(1'b0, 1'b1, 1'b1, SB_RB,   RD_RD,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam ctrl_word_t CW_J     = make_cw(1'b0, 1'b0, 1'b0, SB_RB,   RD_RT,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    localparam ctrl_word_t CW_JAL   = make_cw(1'b0, 1'b0, 1'b0, SB_FOUR, RD_R31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    localparam ctrl_word_t CW_BR    = make_cw(1'b0, 1'b0, 1'b0, SB_SHL2, RD_RT,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    localparam ctrl_word_t CW_IMM   = make_cw(1'b0, 1'b0, 1'b1, SB_SEXT, RD_RT,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam ctrl_word_t CW_LW    = make_cw(1'b0, 1'b0, 1'b1, SB_SEXT, RD_RT,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam ctrl_word_t CW_LB    = make_cw(1'b1, 1'b0, 1'b1, SB_SEXT, RD_RT,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam ctrl_word_t CW_SW    = make_cw(1'b0, 1'b0, 1'b1, SB_SEXT, RD_RT,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    localparam ctrl_word_t CW_SB    = make_cw(1'b1, 1'b0, 1'b1, SB_SEXT, RD_RT,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

endpackage

// File: rtl/main_ctrl_decoder_if.sv
// Opcode-in / control-word-out bundle between instruction latch and datapath FSM.
interface main_ctrl_decoder_if;
    import cpu_ctrl_pkg::*;

    logic [5:0] op;
    ctrl_word_t signal;
    logic       illegal_op;

    modport master (output op, input signal, input illegal_op);
    modport slave  (input op, output signal, output illegal_op);
endinterface

// File: rtl/main_ctrl_comb.sv
// Purely combinational opcode decode table; COP0 decodes to an inert word
// but is legal because the datapath services it directly.
module main_ctrl_comb
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    output ctrl_word_t o_signal,
    output logic       o_illegal
);

    always_comb begin
        o_signal  = '0;
        o_illegal = 1'b0;
        case (i_op)
            OP_RTYPE:                        o_signal = CW_RTYPE;
            OP_J:                            o_signal = CW_J;
            OP_JAL:                          o_signal = CW_JAL;
            OP_BEQ, OP_BNE:                  o_signal = CW_BR;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: o_signal = CW_IMM;
            OP_LW:                           o_signal = CW_LW;
            OP_LB, OP_LBU:                   o_signal = CW_LB;
            OP_SW:                           o_signal = CW_SW;
            OP_SB:                           o_signal = CW_SB;
            OP_COP0:                         o_signal = '0;
            default:                         o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/main_ctrl_decoder.sv
// Main control decoder: registers the combinational decode so the control word
// is valid one cycle after the opcode is latched. Reset clears to an inert word.
module main_ctrl_decoder #(
    parameter int unsigned SIG_W = 14
) (
    input  logic                clk,
    input  logic                rst,
    main_ctrl_decoder_if.slave  ctrl
);

    logic [SIG_W-1:0] w_signal;
    logic             w_illegal;
    logic [SIG_W-1:0] r_signal;
    logic             r_illegal;

    main_ctrl_comb u_comb (
        .i_op      (ctrl.op),
        .o_signal  (w_signal),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_signal  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_signal  <= w_signal;
            r_illegal <= w_illegal;
        end
    end

    assign ctrl.signal     = r_signal;
    assign ctrl.illegal_op = r_illegal;

endmodule

// File: tb/tb_main_ctrl_decoder.sv
// Self-checking bench: opcode table model, sweep, directed, latency, reset and random ops.
module tb_main_ctrl_decoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    main_ctrl_decoder_if bus ();

    main_ctrl_decoder #(.SIG_W(14)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [13:0] exp_sig [64];
    logic        exp_ill [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the registered output against the table entry for the opcode
    // sampled at the last edge, plus the structural invariants of the word.
    task automatic check_op(input string tag, input logic [5:0] op);
        logic [13:0] s;
        s = bus.signal;
        check($sformatf("%s sig op=%02h", tag, op), {18'd0, s}, {18'd0, exp_sig[op]});
        check($sformatf("%s ill op=%02h", tag, op), {31'd0, bus.illegal_op}, {31'd0, exp_ill[op]});
        check($sformatf("%s pcw&pcwc op=%02h", tag, op), {31'd0, s[1] & s[0]}, 32'd0);
        check($sformatf("%s memr&memw op=%02h", tag, op), {31'd0, s[4] & s[3]}, 32'd0);
        check($sformatf("%s m2r_imp op=%02h", tag, op), {31'd0, s[6] & ~(s[4] & s[5])}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [13:0] s_a;
        logic [13:0] s_b;
        logic [5:0]  dir_ops [11];
        logic [5:0]  rop;

        for (int i = 0; i < 64; i++) begin
            exp_sig[i] = 14'h0000;
            exp_ill[i] = 1'b1;
        end
        exp_sig[6'h00] = 14'h18A0; exp_ill[6'h00] = 1'b0;
        exp_sig[6'h02] = 14'h0001; exp_ill[6'h02] = 1'b0;
        exp_sig[6'h03] = 14'h0321; exp_ill[6'h03] = 1'b0;
        exp_sig[6'h04] = 14'h0602; exp_ill[6'h04] = 1'b0;
        exp_sig[6'h05] = 14'h0602; exp_ill[6'h05] = 1'b0;
        for (int i = 8; i <= 15; i++) begin
            exp_sig[i] = 14'h0C20;
            exp_ill[i] = 1'b0;
        end
        exp_sig[6'h23] = 14'h0C70; exp_ill[6'h23] = 1'b0;
        exp_sig[6'h20] = 14'h2C70; exp_ill[6'h20] = 1'b0;
        exp_sig[6'h24] = 14'h2C70; exp_ill[6'h24] = 1'b0;
        exp_sig[6'h2B] = 14'h0C08; exp_ill[6'h2B] = 1'b0;
        exp_sig[6'h28] = 14'h2C08; exp_ill[6'h28] = 1'b0;
        exp_sig[6'h10] = 14'h0000; exp_ill[6'h10] = 1'b0;

        // Power-on reset
        rst    = 1'b1;
        bus.op = 6'h3F;
        #2;
        check("por sig", {18'd0, bus.signal}, 32'h0);
        check("por ill", {31'd0, bus.illegal_op}, 32'h0);
        tick();
        check("por hold sig", {18'd0, bus.signal}, 32'h0);
        check("por hold ill", {31'd0, bus.illegal_op}, 32'h0);

        // First decode after release
        bus.op = 6'h23;
        rst    = 1'b0;
        tick();
        check("first decode", {18'd0, bus.signal}, 32'h0C70);

        // Asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        check("async rst sig", {18'd0, bus.signal}, 32'h0);
        check("async rst ill", {31'd0, bus.illegal_op}, 32'h0);
        tick();
        check("rst held sig", {18'd0, bus.signal}, 32'h0);
        rst = 1'b0;
        tick();
        check("post rst decode", {18'd0, bus.signal}, 32'h0C70);

        // Full sweep on consecutive cycles
        for (int i = 0; i < 64; i++) begin
            bus.op = 6'(i);
            tick();
            check_op("sweep", 6'(i));
        end

        // Directed ops
        dir_ops = '{6'h3F, 6'h01, 6'h10, 6'h24, 6'h23, 6'h28, 6'h2B, 6'h02, 6'h03, 6'h04, 6'h05};
        for (int i = 0; i < 11; i++) begin
            bus.op = dir_ops[i];
            tick();
            check_op("directed", dir_ops[i]);
        end

        // Byte vs word differ only in Membyte
        bus.op = 6'h24; tick(); s_a = bus.signal;
        bus.op = 6'h23; tick(); s_b = bus.signal;
        check("lbu^lw", {18'd0, s_a ^ s_b}, 32'h2000);
        bus.op = 6'h28; tick(); s_a = bus.signal;
        bus.op = 6'h2B; tick(); s_b = bus.signal;
        check("sb^sw", {18'd0, s_a ^ s_b}, 32'h2000);

        // Latency: op change between edges is not visible until the next edge
        bus.op = 6'h00;
        tick();
        check("lat rtype", {18'd0, bus.signal}, 32'h18A0);
        #2;
        bus.op = 6'h2B;
        #1;
        check("lat hold", {18'd0, bus.signal}, 32'h18A0);
        tick();
        check("lat sw", {18'd0, bus.signal}, 32'h0C08);

        // Random opcodes, with occasional mid-cycle reset pulses
        for (int i = 0; i < 300; i++) begin
            rop    = 6'($urandom_range(63));
            bus.op = rop;
            tick();
            check_op("rand", rop);
            if ($urandom_range(19) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check("rand rst sig", {18'd0, bus.signal}, 32'h0);
                check("rand rst ill", {31'd0, bus.illegal_op}, 32'h0);
                tick();
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
